pipe_skid_stage: RTL and testbench
==================================

Name: pipe_skid_stage

Overview:
Parametrised pipeline-stage register, next generation of the fetch/decode stage register. Replaces the single write-enable register with a two-entry ready/valid skid stage. Upstream and downstream stall independently, and no combinational ready path runs through the stage. Adds synchronous flush, an occupancy readout and saturating stall/flush performance counters. Used between any two CPU pipeline stages (IF/ID, ID/EX, ...) with the stage payload struct packed into data.

Parameters:
DATA_W, 64, payload width in bits (packed stage struct)
FLUSH_VAL, '0 (DATA_W bits), value loaded into out_data on reset and flush
CNT_W, 16, width of each performance counter

Ports:
clock  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream has a payload
in_ready  output  1  stage can accept; registered, no combinational path from out_ready
in_data  input  DATA_W  upstream payload
flush  input  1  discard all held and incoming payloads this cycle
out_valid  output  1  out_data holds a valid payload
out_ready  input  1  downstream accepts
out_data  output  DATA_W  oldest held payload
occupancy  output  2  entries held: 0, 1 or 2
stall_cycles  output  CNT_W  cycles with out_valid=1 and out_ready=0
flush_drops  output  CNT_W  flush cycles that discarded at least one payload

Behaviour:
- Reset and clock are decided: reset is synchronous, active-high, named reset; clock is named clock.
- Definitions: accept = in_valid & in_ready; pop = out_valid & out_ready.
- Storage is a main register (drives out_data) plus a skid register. The state is EMPTY, ONE or FULL; occupancy is 0, 1 or 2 respectively.
- Outputs are registered or decoded from state:
  - out_valid = (state != EMPTY)
  - in_ready = (state != FULL)
- Reset values: state EMPTY, out_valid 0, in_ready 1, out_data FLUSH_VAL, skid register FLUSH_VAL, occupancy 0, both counters 0.
- Reset has priority over flush, and both have priority over all transfers.
- Transitions (no flush):
  - EMPTY: accept -> ONE, main <= in_data. Otherwise stay EMPTY.
  - ONE, accept & pop -> ONE, main <= in_data (full throughput, 1 transfer/cycle).
  - ONE, accept & !pop -> FULL, skid <= in_data, main unchanged.
  - ONE, pop & !accept -> EMPTY; main keeps its last value.
  - ONE, neither -> hold.
  - FULL: no accept is possible (in_ready=0). pop -> ONE, main <= skid. Otherwise hold.
- Latency: a payload accepted at edge N is visible on out_data with out_valid=1 after edge N (one cycle) when the stage is EMPTY or popped that cycle.
- Ordering is strictly FIFO. No payload is duplicated or lost except by flush.
- Flush (synchronous) takes effect at the next edge:
  - state <= EMPTY; main and skid <= FLUSH_VAL.
  - An accept in the same cycle is discarded.
  - A pop in the same cycle still completes, because downstream sampled it.
  - in_ready returns to 1 on the next cycle.
- flush_drops increments when flush=1 and (state != EMPTY or accept). A pop-only ONE-state flush does not count.
- stall_cycles increments each cycle with out_valid & !out_ready, including a flush cycle.
- Both counters saturate at all-ones, never wrap, and are cleared only by reset.
- Data is never modified in the stage: out_data equals the accepted in_data bit-for-bit for DATA_W.
- Reset mid-operation: held payloads are discarded silently, and flush_drops does not count them.

Test Plan:
- Reset then idle: after reset, out_valid=0, in_ready=1, out_data=FLUSH_VAL, occupancy=0, counters=0.
- Streaming: out_ready=1, send 0x1..0x8 on consecutive cycles -> out_data 0x1..0x8 one cycle later, one per cycle, occupancy stays 1, stall_cycles=0.
- Backpressure: out_ready=0, send 0xA then 0xB -> occupancy=2, in_ready=0, in_valid with 0xC held. Raise out_ready -> outputs 0xA, 0xB, 0xC in order. stall_cycles equals the number of cycles out_valid=1 with out_ready=0.
- Flush while FULL with in_valid=1: next cycle occupancy=0, out_valid=0, out_data=FLUSH_VAL, in_ready=1, the incoming payload never appears, flush_drops=1.
- Flush with pop in ONE, no accept: the popped payload is counted as delivered, flush_drops unchanged, stage EMPTY next cycle.
- Counter saturation (CNT_W=4): hold out_ready=0 for 20 cycles with one entry -> stall_cycles sticks at 15. Reset clears both counters to 0.

Source files
------------

// File: rtl/pipe_skid_stage.sv
// Two-entry ready/valid skid stage between CPU pipeline stages.
// in_ready is decoded from registered state only, so out_ready never reaches it combinationally.
module pipe_skid_stage #(
  parameter int                 DATA_W    = 64,
  parameter logic [DATA_W-1:0]  FLUSH_VAL = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_drops
);

  // state    | meaning
  // ST_EMPTY | nothing held, out_valid low
  // ST_ONE   | main register holds the oldest payload
  // ST_FULL  | main holds oldest, skid holds the next one; upstream stalled
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]        state, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              accept, pop;
  logic              stall_inc, drop_inc;

  assign out_valid = (state != ST_EMPTY);
  assign in_ready  = (state != ST_FULL);
  assign out_data  = main_q;
  assign occupancy = state;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  always_comb begin
    state_d = state;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = FLUSH_VAL;
      skid_d  = FLUSH_VAL;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            main_d = in_data;
          end else if (accept) begin
            state_d = ST_FULL;
            skid_d  = in_data;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // A flush drops something unless the only held payload leaves by pop this cycle.
  assign stall_inc = out_valid & ~out_ready;
  assign drop_inc  = flush & (accept | (state == ST_FULL) | ((state == ST_ONE) & ~pop));

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_EMPTY;
      main_q       <= FLUSH_VAL;
      skid_q       <= FLUSH_VAL;
      stall_cycles <= '0;
      flush_drops  <= '0;
    end else begin
      state  <= state_d;
      main_q <= main_d;
      skid_q <= skid_d;
      if (stall_inc && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (drop_inc && (flush_drops != '1))
        flush_drops <= flush_drops + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed scenarios then random traffic, all checked
// each cycle against a queue-based reference model.
module tb_pipe_skid_stage;

  localparam int          DW  = 16;
  localparam int          CW  = 4;
  localparam logic [15:0] FV  = 16'hDEAD;
  localparam int          SAT = 15;

  logic          clock = 1'b0;
  logic          reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cycles, flush_drops;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] idle_data;
  int            stall_m, drop_m;

  always #5 clock = ~clock;

  pipe_skid_stage #(.DATA_W(DW), .FLUSH_VAL(FV), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cycles(stall_cycles), .flush_drops(flush_drops)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: predict from the model's pre-edge contents, then compare after the edge.
  task automatic cycle();
    int          sz;
    bit          acc, pp;
    logic [DW-1:0] exp_data;
    sz  = q.size();
    acc = in_valid && (sz < 2);
    pp  = (sz > 0) && out_ready;
    @(posedge clock);
    #1;
    if (reset) begin
      q.delete();
      idle_data = FV;
      stall_m = 0;
      drop_m = 0;
    end else begin
      if (sz > 0 && !out_ready && stall_m < SAT) stall_m++;
      if (flush) begin
        if ((acc || sz > (pp ? 1 : 0)) && drop_m < SAT) drop_m++;
        q.delete();
        idle_data = FV;
      end else begin
        if (pp) idle_data = q.pop_front();
        if (acc) q.push_back(in_data);
      end
    end
    exp_data = (q.size() > 0) ? q[0] : idle_data;
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("occupancy", 32'(occupancy), 32'(q.size()));
    chk("out_data", 32'(out_data), 32'(exp_data));
    chk("stall_cycles", 32'(stall_cycles), 32'(stall_m));
    chk("flush_drops", 32'(flush_drops), 32'(drop_m));
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_data = '0;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    q.delete();
    idle_data = FV;
    stall_m = 0;
    drop_m = 0;

    // reset then idle
    do_reset();
    chk("reset_out_data", 32'(out_data), 32'(FV));
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    repeat (3) cycle();

    // streaming 1..8 with downstream always ready
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = DW'(i);
      cycle();
      chk("stream_data", 32'(out_data), 32'(i));
      chk("stream_occ", 32'(occupancy), 32'd1);
    end
    in_valid = 1'b0;
    cycle();
    chk("stream_stall", 32'(stall_cycles), 32'd0);

    // backpressure: A, B fill the stage, C waits
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h000A; cycle();
    in_data = 16'h000B; cycle();
    chk("bp_occ_full", 32'(occupancy), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    in_data = 16'h000C; cycle(); cycle();
    out_ready = 1'b1;
    cycle();
    chk("bp_first", 32'(out_data), 32'h000B);
    cycle();
    in_valid = 1'b0;
    chk("bp_second", 32'(out_data), 32'h000C);
    cycle(); cycle();
    chk("bp_stall", 32'(stall_cycles), 32'd3);

    // flush while FULL with an incoming payload
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0011; cycle();
    in_data = 16'h0022; cycle();
    in_data = 16'h0033; flush = 1'b1; cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_full_occ", 32'(occupancy), 32'd0);
    chk("flush_full_data", 32'(out_data), 32'(FV));
    chk("flush_full_drops", 32'(flush_drops), 32'd1);
    out_ready = 1'b1;
    cycle();
    chk("flush_full_nothing", 32'(out_valid), 32'd0);

    // flush coinciding with a pop in ONE, no accept
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0044; cycle();
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1; cycle();
    flush = 1'b0;
    chk("flush_pop_drops", 32'(flush_drops), 32'd0);
    chk("flush_pop_occ", 32'(occupancy), 32'd0);
    cycle();

    // stall counter saturation
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0005; cycle();
    in_valid = 1'b0;
    repeat (20) cycle();
    chk("stall_sat", 32'(stall_cycles), 32'd15);
    in_valid = 1'b1; flush = 1'b1; cycle();
    flush = 1'b0; in_valid = 1'b0;
    do_reset();
    chk("reset_clr_stall", 32'(stall_cycles), 32'd0);
    chk("reset_clr_drops", 32'(flush_drops), 32'd0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      reset     = ($urandom_range(0, 199) == 0);
      in_data   = DW'($urandom);
      cycle();
    end
    reset = 1'b0; flush = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
